// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter over 8 request lines with a registered one-hot grant held until ack.
// Optional macro RR_BACK2BACK_EN: re-arbitrate on the ack edge so grants follow with no bubble.
module rr_onehot_arbiter #(
  parameter int N     = 8,
  parameter int PTR_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         gnt_ack,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  output logic         busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } pick_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] sel_q, sel_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [PTR_W-1:0] ptr_after_sel;
  pick_t            pick_idle;

  // Rotate the request vector so the pointer lands on bit 0, take the lowest set
  // bit, then add the pointer back; PTR_W-bit addition gives the mod-8 wrap.
  function automatic pick_t rr_pick(input logic [N-1:0] r, input logic [PTR_W-1:0] p);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    pick_t          res;
    dbl       = {r, r};
    rot       = dbl[p +: N];
    res.found = |r;
    res.idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) res.idx = p + PTR_W'(i);
    end
    return res;
  endfunction

  assign ptr_after_sel = sel_q + PTR_W'(1);
  assign pick_idle     = rr_pick(req, ptr_q);

`ifdef RR_BACK2BACK_EN
  pick_t pick_next;
  // The line being released is masked out so it cannot win again on its own ack.
  assign pick_next = rr_pick(req & ~gnt_q, ptr_after_sel);
`endif

  // NOTE: every variable driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_idle.found) begin
          state_d = GRANT;
          sel_d   = pick_idle.idx;
          gnt_d   = N'(1) << pick_idle.idx;
        end
      end
      GRANT: begin
        if (gnt_ack) begin
          ptr_d = ptr_after_sel;
`ifdef RR_BACK2BACK_EN
          if (pick_next.found) begin
            sel_d = pick_next.idx;
            gnt_d = N'(1) << pick_next.idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
`else
          state_d = IDLE;
          gnt_d   = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  // gnt is only ever loaded with a single shifted bit or zero, so it is one-hot-or-zero.
  assign gnt       = gnt_q;
  assign gnt_valid = (state_q == GRANT);
  assign busy      = gnt_valid;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter: directed vector table, multi-cycle
// corner sequences and randomized traffic against a scan-based reference model.
module tb_rr_onehot_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       gnt_ack;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: index of the live grant (-1 when none) and priority pointer.
  int m_sel;
  int m_ptr;

  typedef struct {
    logic [7:0] req;
    logic       ack;
    logic [7:0] exp_gnt;
  } vec_t;

  vec_t vecs[$];

  rr_onehot_arbiter #(.N(8), .PTR_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt_ack  (gnt_ack),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int scan(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_gnt();
    if (m_sel < 0) return 8'h00;
    return 8'(1 << m_sel);
  endfunction

  task automatic model_edge(input logic [7:0] r, input logic a);
    logic [7:0] rest;
    if (m_sel < 0) begin
      m_sel = scan(r, m_ptr);
    end else if (a) begin
      m_ptr = (m_sel + 1) % 8;
      rest  = r;
      rest[m_sel] = 1'b0;
`ifdef RR_BACK2BACK_EN
      m_sel = scan(rest, m_ptr);
`else
      m_sel = -1;
`endif
    end
  endtask

  task automatic check_invariants();
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
    check("valid_eq_nonzero", 32'(gnt_valid), 32'(gnt != 8'h00));
    check("busy_eq_valid", 32'(busy), 32'(gnt_valid));
  endtask

  // Drive inputs, take one edge, update the model with what the DUT saw, sample #1 later.
  task automatic step(input logic [7:0] r, input logic a);
    req     = r;
    gnt_ack = a;
    @(posedge clk);
    model_edge(r, a);
    #1;
    check("model_gnt", 32'(gnt), 32'(model_gnt()));
    check("model_valid", 32'(gnt_valid), 32'(m_sel >= 0));
    check_invariants();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = 8'hFF;
    gnt_ack = 1'b0;
    #1;
    check("reset_async_gnt", 32'(gnt), 32'h00);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_gnt", 32'(gnt), 32'h00);
      check("reset_valid", 32'(gnt_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
    end
    m_sel = -1;
    m_ptr = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    m_sel = -1;
    m_ptr = 0;
    do_reset();

    // Ordering from reset; the third grant proves ptr=3 after the second ack.
`ifdef RR_BACK2BACK_EN
    vecs.push_back('{8'h05, 1'b0, 8'h01});
    vecs.push_back('{8'h05, 1'b1, 8'h04});
    vecs.push_back('{8'h05, 1'b1, 8'h01});
    vecs.push_back('{8'h00, 1'b1, 8'h00});
`else
    vecs.push_back('{8'h05, 1'b0, 8'h01});
    vecs.push_back('{8'h05, 1'b1, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h04});
    vecs.push_back('{8'h05, 1'b1, 8'h00});
    vecs.push_back('{8'h05, 1'b0, 8'h01});
    vecs.push_back('{8'h00, 1'b1, 8'h00});
`endif
    // Wrap: grant bit 7, ack, then 8'h81 must pick bit 0.
    vecs.push_back('{8'h80, 1'b0, 8'h80});
    vecs.push_back('{8'h80, 1'b1, 8'h00});
    vecs.push_back('{8'h81, 1'b0, 8'h01});
    vecs.push_back('{8'h00, 1'b1, 8'h00});
    // Ack while idle is ignored; no requests keeps outputs at zero.
    vecs.push_back('{8'h00, 1'b1, 8'h00});
    vecs.push_back('{8'h00, 1'b0, 8'h00});
    // Hold: grant 8'h10 survives its request dropping for five cycles.
    vecs.push_back('{8'h10, 1'b0, 8'h10});
    for (int i = 0; i < 5; i++) vecs.push_back('{8'h00, 1'b0, 8'h10});
    vecs.push_back('{8'h00, 1'b1, 8'h00});
    // Pointer now at 5 after releasing line 4.
    vecs.push_back('{8'hFF, 1'b0, 8'h20});
    vecs.push_back('{8'h00, 1'b1, 8'h00});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].req, vecs[i].ack);
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
    end

    // Async reset mid-grant clears outputs with no clock edge.
    do_reset();
    step(8'h40, 1'b0);
    check("pre_reset_gnt", 32'(gnt), 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check("midgrant_reset_gnt", 32'(gnt), 32'h00);
    check("midgrant_reset_valid", 32'(gnt_valid), 32'd0);
    check("midgrant_reset_busy", 32'(busy), 32'd0);
    m_sel = -1;
    m_ptr = 0;
    #1;
    rst_n = 1'b1;
    step(8'hC0, 1'b0);
    check("post_reset_gnt", 32'(gnt), 32'h40);

    // Stream with every line requesting and ack tied high.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      logic [7:0] exp;
`ifdef RR_BACK2BACK_EN
      exp = 8'(1 << (i % 8));
`else
      exp = (i % 2 == 0) ? 8'(1 << ((i / 2) % 8)) : 8'h00;
`endif
      step(8'hFF, 1'b1);
      check($sformatf("stream%0d", i), 32'(gnt), 32'(exp));
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      logic       a;
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      a = ($urandom_range(0, 2) == 0);
      step(r, a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
